equalizer_cmul_sat: RTL and testbench

//  Complex multiply of one equalizer sample by its channel-correction coefficient.

---
 rtl/equalizer_cmul_sat.sv | 180 ++++++++++++++++++
 tb/tb_equalizer_cmul_sat.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/equalizer_cmul_sat.sv
// -----------------------------------------------------------------------------
// equalizer_cmul_sat
//   Complex multiply of one equalizer sample (a) by its channel-correction
//   coefficient (b). Four 16x16 signed 4-stage multipliers produce
//   ar*br, ai*bi, ar*bi and ai*br. These are combined into re/im, rounded
//   half up, arithmetically shifted right by SHIFT and saturated to OUT_W
//   bits. The result lands in the output register.
//
//   Optional feature macro: EQ_CMUL_SAT_CNT_EN
//     When defined, this adds the saturation event counter sat_cnt and its
//     synchronous clear sat_clr.
//
// Ports
//   clk            rising-edge clock
//   reset_n        asynchronous active-low reset
//   s_valid/s_ready/s_last   input handshake and end-of-symbol tag
//   s_ar/s_ai      signed sample I/Q
//   s_br/s_bi      signed coefficient I/Q
//   m_valid/m_ready/m_last   output handshake and end-of-symbol tag
//   m_re/m_im      signed rounded and saturated result
//   m_sat          set when re or im of this output was clipped
//   sat_cnt        saturation event count (EQ_CMUL_SAT_CNT_EN only)
//   sat_clr        synchronous clear of sat_cnt (EQ_CMUL_SAT_CNT_EN only)
//
// Handshake: a transfer occurs on a rising edge where valid and ready are
// both high. Once m_valid is asserted, m_valid and the output data hold
// until m_ready is seen. s_ready never depends on s_valid.
// -----------------------------------------------------------------------------

module equalizer_mul_mul_16s_16s_32_4_1 (
  input  logic               clk,
  input  logic               ce,
  input  logic signed [15:0] din0,
  input  logic signed [15:0] din1,
  output logic signed [31:0] dout
);
  // The data registers are left unreset on purpose. The valid pipe in the
  // parent masks whatever they hold after reset.
  logic signed [15:0] a_r, b_r;
  logic signed [31:0] m1_r, m2_r, m3_r;

  always_ff @(posedge clk) begin
    if (ce) begin
      a_r  <= din0;
      b_r  <= din1;
      m1_r <= a_r * b_r;
      m2_r <= m1_r;
      m3_r <= m2_r;
    end
  end

  assign dout = m3_r;
endmodule

module equalizer_cmul_sat #(
  parameter int SHIFT = 15,
  parameter int OUT_W = 16
`ifdef EQ_CMUL_SAT_CNT_EN
  ,
  parameter int CNT_W = 16
`endif
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic                    s_last,
  input  logic signed [15:0]      s_ar,
  input  logic signed [15:0]      s_ai,
  input  logic signed [15:0]      s_br,
  input  logic signed [15:0]      s_bi,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic signed [OUT_W-1:0] m_re,
  output logic signed [OUT_W-1:0] m_im,
  output logic                    m_sat
`ifdef EQ_CMUL_SAT_CNT_EN
  ,
  output logic [CNT_W-1:0]        sat_cnt,
  input  logic                    sat_clr
`endif
);

  localparam logic signed [33:0] RND   = 34'sd1 <<< (SHIFT - 1);
  localparam logic signed [33:0] MAX_V = (34'sd1 <<< (OUT_W - 1)) - 34'sd1;
  localparam logic signed [33:0] MIN_V = -(34'sd1 <<< (OUT_W - 1));

  logic                ce;
  logic [3:0]          v_pipe;
  logic [3:0]          l_pipe;
  logic signed [31:0]  p0, p1, p2, p3;
  logic signed [33:0]  re_sum, im_sum, re_sh, im_sh;
  logic [OUT_W-1:0]    re_sat, im_sat;
  logic                re_clip, im_clip;

  // The whole pipe advances together. The output stage is allowed to move
  // whenever it is empty or being drained.
  assign ce      = ~m_valid | m_ready;
  assign s_ready = ce;

  equalizer_mul_mul_16s_16s_32_4_1 u_mul0 (.clk(clk), .ce(ce), .din0(s_ar), .din1(s_br), .dout(p0));
  equalizer_mul_mul_16s_16s_32_4_1 u_mul1 (.clk(clk), .ce(ce), .din0(s_ai), .din1(s_bi), .dout(p1));
  equalizer_mul_mul_16s_16s_32_4_1 u_mul2 (.clk(clk), .ce(ce), .din0(s_ar), .din1(s_bi), .dout(p2));
  equalizer_mul_mul_16s_16s_32_4_1 u_mul3 (.clk(clk), .ce(ce), .din0(s_ai), .din1(s_br), .dout(p3));

  // The tags travel alongside the products. While ce is high, an idle input
  // shifts a bubble into the pipe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_pipe <= '0;
      l_pipe <= '0;
    end else if (ce) begin
      v_pipe <= {v_pipe[2:0], s_valid};
      l_pipe <= {l_pipe[2:0], s_valid & s_last};
    end
  end

  // The sums need 33 bits, and adding RND needs one more bit of headroom.
  assign re_sum = $signed({{2{p0[31]}}, p0}) - $signed({{2{p1[31]}}, p1});
  assign im_sum = $signed({{2{p2[31]}}, p2}) + $signed({{2{p3[31]}}, p3});
  assign re_sh  = (re_sum + RND) >>> SHIFT;
  assign im_sh  = (im_sum + RND) >>> SHIFT;

  always_comb begin
    re_clip = 1'b0;
    im_clip = 1'b0;
    re_sat  = re_sh[OUT_W-1:0];
    im_sat  = im_sh[OUT_W-1:0];
    if (re_sh > MAX_V) begin
      re_sat  = MAX_V[OUT_W-1:0];
      re_clip = 1'b1;
    end else if (re_sh < MIN_V) begin
      re_sat  = MIN_V[OUT_W-1:0];
      re_clip = 1'b1;
    end
    if (im_sh > MAX_V) begin
      im_sat  = MAX_V[OUT_W-1:0];
      im_clip = 1'b1;
    end else if (im_sh < MIN_V) begin
      im_sat  = MIN_V[OUT_W-1:0];
      im_clip = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      m_re    <= '0;
      m_im    <= '0;
      m_sat   <= 1'b0;
    end else if (ce) begin
      m_valid <= v_pipe[3];
      m_last  <= l_pipe[3];
      m_sat   <= v_pipe[3] & (re_clip | im_clip);
      // The data is loaded only for real samples, so bubbles never expose
      // the unreset multiplier contents.
      if (v_pipe[3]) begin
        m_re <= re_sat;
        m_im <= im_sat;
      end
    end
  end

`ifdef EQ_CMUL_SAT_CNT_EN
  // The clear has priority over a same-cycle increment. The count sticks at
  // all-ones and does not wrap.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_cnt <= '0;
    end else if (sat_clr) begin
      sat_cnt <= '0;
    end else if (m_valid && m_ready && m_sat && !(&sat_cnt)) begin
      sat_cnt <= sat_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_equalizer_cmul_sat.sv
// -----------------------------------------------------------------------------
// tb_equalizer_cmul_sat
//   Directed bench for equalizer_cmul_sat. The expected values are worked
//   out by hand from the rounding and saturation rules. They are either
//   given as constants or given by a closed-form formula for the streaming
//   sequence. Define EQ_CMUL_SAT_CNT_EN to include the counter scenario,
//   which builds the DUT with CNT_W=4.
// -----------------------------------------------------------------------------

module tb_equalizer_cmul_sat;

  logic               clk;
  logic               reset_n;
  logic               s_valid;
  logic               s_ready;
  logic               s_last;
  logic signed [15:0] s_ar, s_ai, s_br, s_bi;
  logic               m_valid;
  logic               m_ready;
  logic               m_last;
  logic signed [15:0] m_re, m_im;
  logic               m_sat;
`ifdef EQ_CMUL_SAT_CNT_EN
  logic [3:0]         sat_cnt;
  logic               sat_clr;
`endif

  int n_checks;
  int n_errors;
  logic [32:0] exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  equalizer_cmul_sat #(
    .SHIFT(15),
    .OUT_W(16)
`ifdef EQ_CMUL_SAT_CNT_EN
    ,
    .CNT_W(4)
`endif
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_last  (s_last),
    .s_ar    (s_ar),
    .s_ai    (s_ai),
    .s_br    (s_br),
    .s_bi    (s_bi),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_last  (m_last),
    .m_re    (m_re),
    .m_im    (m_im),
    .m_sat   (m_sat)
`ifdef EQ_CMUL_SAT_CNT_EN
    ,
    .sat_cnt (sat_cnt),
    .sat_clr (sat_clr)
`endif
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Sends one sample with m_ready high and waits for its output. It then
  // checks latency, data and flag, and completes the output transfer.
  // If clr is set, sat_clr is raised on the transfer edge.
  task automatic run_one(input string tag,
                         input logic signed [15:0] ar, input logic signed [15:0] ai,
                         input logic signed [15:0] br, input logic signed [15:0] bi,
                         input logic signed [15:0] er, input logic signed [15:0] ei,
                         input logic es, input logic clr);
    int lat;
    s_ar = ar; s_ai = ai; s_br = br; s_bi = bi;
    s_last  = 1'b0;
    s_valid = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      if (m_valid) begin
        lat = k;
        break;
      end
      @(posedge clk); #1;
    end
    check({tag, "_latency"}, lat, 5);
    check({tag, "_re"}, m_re, er);
    check({tag, "_im"}, m_im, ei);
    check({tag, "_sat"}, m_sat, es);
`ifdef EQ_CMUL_SAT_CNT_EN
    sat_clr = clr;
`endif
    @(posedge clk); #1;
`ifdef EQ_CMUL_SAT_CNT_EN
    sat_clr = 1'b0;
`endif
    check({tag, "_no_dup"}, m_valid, 0);
    if (clr && 0) n_checks = n_checks;
  endtask

  function automatic logic [32:0] stream_exp(input int i);
    logic [15:0] re, im;
    re = 16'(i * 50);
    im = 16'((i + 1) / 2);
    return {(i == 20), re, im};
  endfunction

  task automatic drive_stream(input int i);
    s_ar   = 16'(i * 100);
    s_ai   = 16'(i);
    s_br   = 16'sd16384;
    s_bi   = 16'sd0;
    s_last = (i == 20);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int idx;
    int rx;
    int hold;
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    s_valid  = 1'b0;
    s_last   = 1'b0;
    s_ar = '0; s_ai = '0; s_br = '0; s_bi = '0;
    m_ready  = 1'b1;
`ifdef EQ_CMUL_SAT_CNT_EN
    sat_clr  = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_re", m_re, 0);
    check("rst_m_im", m_im, 0);
    check("rst_m_sat", m_sat, 0);
    check("rst_s_ready", s_ready, 1);
`ifdef EQ_CMUL_SAT_CNT_EN
    check("rst_sat_cnt", sat_cnt, 0);
`endif
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Basic directed vectors.
    run_one("unity_half", 16384, 0, 16384, 0, 8192, 0, 1'b0, 1'b0);
    run_one("pos_clip", -32768, 0, -32768, 0, 32767, 0, 1'b1, 1'b0);
    run_one("round_im", 100, 100, 100, 100, 0, 1, 1'b0, 1'b0);
    run_one("half_up_pos", 1, 0, 16384, 0, 1, 0, 1'b0, 1'b0);
    run_one("half_up_neg", -1, 0, 16384, 0, 0, 0, 1'b0, 1'b0);
    run_one("neg_clip", -32768, 32767, 32767, 32767, -32768, -1, 1'b1, 1'b0);

    // Streaming: 20 back-to-back items. m_ready toggles 1010 while items
    // are sent, then is held low for 6 cycles, then drains.
    exp_q.delete();
    idx = 1; rx = 0; hold = 0;
    drive_stream(1);
    s_valid = 1'b1;
    m_ready = 1'b1;
    for (int cyc = 0; cyc < 300 && rx < 20; cyc++) begin
      @(negedge clk);
      if (m_valid) begin
        if (exp_q.size() == 0) begin
          check("stream_spurious", 1, 0);
        end else begin
          check("stream_data", {m_last, m_re, m_im}, exp_q[0]);
          if (m_ready) begin
            void'(exp_q.pop_front());
            rx++;
          end
        end
        if (!m_ready) check("stream_s_ready_stall", s_ready, 0);
      end
      if (s_valid && s_ready) begin
        exp_q.push_back(stream_exp(idx));
        idx++;
      end
      @(posedge clk); #1;
      if (idx <= 20) begin
        drive_stream(idx);
        s_valid = 1'b1;
        m_ready = ~m_ready;
      end else begin
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (hold < 6) begin
          m_ready = 1'b0;
          hold++;
        end else begin
          m_ready = 1'b1;
        end
      end
    end
    check("stream_count", rx, 20);
    m_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("stream_drained", m_valid, 0);
    end
    @(posedge clk); #1;

    // Reset with three samples in flight.
    s_ar = 16'sd16384; s_ai = 0; s_br = 16'sd16384; s_bi = 0; s_last = 1'b1;
    s_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    reset_n = 1'b0;
    #1;
    check("midrst_m_valid", m_valid, 0);
    check("midrst_m_re", m_re, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    run_one("after_rst", -16384, 0, 16384, 0, -8192, 0, 1'b0, 1'b0);

`ifdef EQ_CMUL_SAT_CNT_EN
    // Saturation counter (CNT_W = 4).
    for (int k = 0; k < 3; k++)
      run_one("cnt_ev", -32768, 0, -32768, 0, 32767, 0, 1'b1, 1'b0);
    check("cnt_three", sat_cnt, 3);
    run_one("cnt_clr", -32768, 0, -32768, 0, 32767, 0, 1'b1, 1'b1);
    check("cnt_clr_wins", sat_cnt, 0);
    run_one("cnt_nosat", 16384, 0, 16384, 0, 8192, 0, 1'b0, 1'b0);
    check("cnt_nosat_hold", sat_cnt, 0);
    for (int k = 0; k < 15; k++)
      run_one("cnt_fill", -32768, 0, -32768, 0, 32767, 0, 1'b1, 1'b0);
    check("cnt_full", sat_cnt, 15);
    for (int k = 0; k < 2; k++)
      run_one("cnt_over", -32768, 0, -32768, 0, 32767, 0, 1'b1, 1'b0);
    check("cnt_sticky", sat_cnt, 15);
`endif

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
